// File: rtl/veripong_pkg.sv
// Shared widths, screen defaults and types for the rectangle filler.
package veripong_pkg;

   localparam int unsigned SCREEN_W_DEF = 320;
   localparam int unsigned SCREEN_H_DEF = 240;
   localparam int unsigned X_W          = 9;
   localparam int unsigned Y_W          = 8;
   localparam int unsigned COL_W        = 3;

   typedef logic [COL_W-1:0] colour_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage : veripong_pkg

// File: rtl/xy_scan.sv
// Raster-order 2-D offset counter: cx runs fastest over 0..w-1, cy over 0..h-1.
// The next-offset and last outputs are combinational so the owner can
// register the coming pixel in the same edge that advances the counter.
module xy_scan
   import veripong_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic           en_i,
   input  logic [X_W-1:0] w_i,
   input  logic [Y_W-1:0] h_i,
   output logic [X_W-1:0] cx_nxt_o,
   output logic [Y_W-1:0] cy_nxt_o,
   output logic           last_o
);

   logic [X_W-1:0] cx_q, w_q;
   logic [Y_W-1:0] cy_q, h_q;
   logic           last_col, last_row;

   // Wrap detection and next offset in raster order
   always_comb begin
      last_col = (cx_q == (w_q - X_W'(1)));
      last_row = (cy_q == (h_q - Y_W'(1)));
      cx_nxt_o = last_col ? '0 : (cx_q + X_W'(1));
      cy_nxt_o = cy_q;
      if (last_col) begin
         cy_nxt_o = last_row ? '0 : (cy_q + Y_W'(1));
      end
      last_o = last_col && last_row;
   end

   // Offset and size registers; load restarts at (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         cx_q <= '0;
         cy_q <= '0;
         w_q  <= '0;
         h_q  <= '0;
      end else if (load_i) begin
         cx_q <= '0;
         cy_q <= '0;
         w_q  <= w_i;
         h_q  <= h_i;
      end else if (en_i) begin
         cx_q <= cx_nxt_o;
         cy_q <= cy_nxt_o;
      end
   end

endmodule : xy_scan

// File: rtl/rect_fill.sv
// Solid rectangle filler: one pixel per cycle to a VGA adapter, with clipping.
module rect_fill
   import veripong_pkg::*;
#(
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [X_W-1:0] x0,
   input  logic [Y_W-1:0] y0,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   input  colour_t        colour_in,
   output logic           busy,
   output logic           done,
   output logic           plot,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output colour_t        colour
);

   state_t         state_q;
   logic [X_W-1:0] x0_q, x_q;
   logic [Y_W-1:0] y0_q, y_q;
   colour_t        col_q, colour_q, px_col;
   logic           busy_q, done_q, plot_q;

   logic [X_W-1:0] cx_nxt, bx, ox;
   logic [Y_W-1:0] cy_nxt, by, oy;
   logic [X_W:0]   px;
   logic [Y_W:0]   py;
   logic           last, clip, empty, load, adv;

   xy_scan u_scan (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .en_i     (adv),
      .w_i      (w),
      .h_i      (h),
      .cx_nxt_o (cx_nxt),
      .cy_nxt_o (cy_nxt),
      .last_o   (last)
   );

   // Coordinates of the pixel to be emitted after the coming edge
   always_comb begin
      bx     = x0_q;
      by     = y0_q;
      ox     = cx_nxt;
      oy     = cy_nxt;
      px_col = col_q;
      if (state_q == ST_IDLE) begin
         bx     = x0;
         by     = y0;
         ox     = '0;
         oy     = '0;
         px_col = colour_in;
      end
      px    = (X_W+1)'(bx) + (X_W+1)'(ox);
      py    = (Y_W+1)'(by) + (Y_W+1)'(oy);
      clip  = (32'(px) >= SCREEN_W) || (32'(py) >= SCREEN_H);
      empty = (w == '0) || (h == '0);
      load  = (state_q == ST_IDLE) && start;
      adv   = (state_q == ST_FILL) && !last;
   end

   // Control FSM with registered outputs; pixel outputs only move when plotted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         col_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         done_q <= 1'b0;
         plot_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  x0_q   <= x0;
                  y0_q   <= y0;
                  col_q  <= colour_in;
                  busy_q <= 1'b1;
                  if (empty) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FILL;
                     plot_q  <= !clip;
                     if (!clip) begin
                        x_q      <= px[X_W-1:0];
                        y_q      <= py[Y_W-1:0];
                        colour_q <= px_col;
                     end
                  end
               end
            end
            ST_FILL: begin
               if (last) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
               end else begin
                  plot_q <= !clip;
                  if (!clip) begin
                     x_q      <= px[X_W-1:0];
                     y_q      <= py[Y_W-1:0];
                     colour_q <= px_col;
                  end
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign plot   = plot_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;

endmodule : rect_fill
